// File: rtl/chan_arb_pkg.sv
// Shared types for the channel packet arbiter.
// Arbitration mode and arbiter FSM state encodings.
package chan_arb_pkg;

   typedef enum logic {
      ARB_RR,
      ARB_FIXED
   } arb_mode_e;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } arb_state_e;

endpackage

// File: rtl/chan_fifo.sv
// Per-channel beat FIFO, power-of-two depth.
// Read data is the head entry, valid while not empty.
module chan_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];

   // Pointers wrap naturally; count tracks occupancy 0..DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; the count gates what is visible.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/chan_pkt_arbiter.sv
// N-channel packet arbiter with per-channel FIFOs.
// Packets are never interleaved; output is one register stage.
module chan_pkt_arbiter
   import chan_arb_pkg::*;
#(
   parameter int        NUM_CH = 4,
   parameter int        DATA_W = 8,
   parameter int        DEPTH  = 4,
   parameter arb_mode_e MODE   = ARB_RR
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_CH-1:0]         ch_enable,
   input  logic [NUM_CH-1:0]         in_valid,
   output logic [NUM_CH-1:0]         in_ready,
   input  logic [DATA_W-1:0]         in_data [NUM_CH],
   input  logic [NUM_CH-1:0]         in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic                      out_last,
   output logic [$clog2(NUM_CH)-1:0] out_ch
);

   localparam int CH_W = $clog2(NUM_CH);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              last;
   } beat_t;

   beat_t             fifo_rd [NUM_CH];
   logic [NUM_CH-1:0] full;
   logic [NUM_CH-1:0] empty;
   logic [NUM_CH-1:0] pop;
   logic [NUM_CH-1:0] cand;

   arb_state_e        state_q, state_d;
   logic [CH_W-1:0]   lock_ch_q, lock_ch_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic              grant_vld;
   logic [CH_W-1:0]   grant_ch;
   beat_t             sel_beat;
   logic              load_en;
   logic              do_pop;

   logic              out_valid_q;
   logic [DATA_W-1:0] out_data_q;
   logic              out_last_q;
   logic [CH_W-1:0]   out_ch_q;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_fifo
         chan_fifo #(
            .WIDTH ($bits(beat_t)),
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (in_valid[gi]),
            .wdata ({in_data[gi], in_last[gi]}),
            .pop   (pop[gi]),
            .rdata (fifo_rd[gi]),
            .full  (full[gi]),
            .empty (empty[gi])
         );
      end
   endgenerate

   assign in_ready = ~full;
   assign cand     = ~empty & ch_enable;
   assign load_en  = ~out_valid_q | out_ready;
   assign sel_beat = fifo_rd[grant_ch];
   assign do_pop   = load_en & grant_vld;

   // Grant selection: search candidates when idle, else stay on locked channel.
   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_ch  = '0;
      unique case (state_q)
         ST_IDLE: begin
            if (MODE == ARB_FIXED) begin
               for (int i = NUM_CH-1; i >= 0; i--) begin
                  if (cand[i]) begin
                     grant_vld = 1'b1;
                     grant_ch  = CH_W'(i);
                  end
               end
            end else begin
               for (int k = NUM_CH-1; k >= 0; k--) begin
                  idx = int'(rr_ptr_q) + k;
                  if (idx >= NUM_CH) idx = idx - NUM_CH;
                  if (cand[idx]) begin
                     grant_vld = 1'b1;
                     grant_ch  = CH_W'(idx);
                  end
               end
            end
         end
         ST_LOCKED: begin
            if (!empty[lock_ch_q]) begin
               grant_vld = 1'b1;
               grant_ch  = lock_ch_q;
            end
         end
         default: ;
      endcase
   end

   // Pop strobe toward the granted FIFO only when the output can load.
   always_comb begin
      pop = '0;
      if (do_pop) pop[grant_ch] = 1'b1;
   end

   // Next state: lock on a non-last beat, release and rotate on last.
   always_comb begin
      state_d   = state_q;
      lock_ch_d = lock_ch_q;
      rr_ptr_d  = rr_ptr_q;
      if (do_pop) begin
         if (sel_beat.last) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (grant_ch == CH_W'(NUM_CH-1)) ?
                       '0 : grant_ch + CH_W'(1);
         end else begin
            state_d   = ST_LOCKED;
            lock_ch_d = grant_ch;
         end
      end
   end

   // Arbiter state, locked channel and rotation pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         lock_ch_q <= '0;
         rr_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         lock_ch_q <= lock_ch_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   // Output register: loads when empty or when the held beat is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_ch_q    <= '0;
      end else if (load_en) begin
         out_valid_q <= grant_vld;
         if (grant_vld) begin
            out_data_q <= sel_beat.data;
            out_last_q <= sel_beat.last;
            out_ch_q   <= grant_ch;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_ch    = out_ch_q;

endmodule
